lsu_port: RTL

- Per-thread load/store unit: the consumer sitting directly upstream of the data memory controller.
- Accepts one load or store per request from the warp execution stage and drives one consumer slot of the controller with the four-phase valid/ready protocol.
- Returns load data and store completion to the core as a one-cycle response pulse.
- One in-flight request; no queuing.

---
 rtl/lsu_port.sv | 92 +++++++++
 1 files changed

// File: rtl/lsu_port.sv
// lsu_port: single in-flight load/store unit driving one four-phase valid/ready slot of the memory controller.
// Optional LSU_TIMEOUT_EN adds a sticky timeout flag for requests stuck in REQUESTING.
module lsu_port #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDRESS_WIDTH  = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ADDRESS_WIDTH-1:0] req_address,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     rsp_valid,
  output logic                     rsp_write,
  output logic [DATA_WIDTH-1:0]    rsp_data,
  output logic                     busy,
  output logic                     mem_read_valid,
  output logic [ADDRESS_WIDTH-1:0] mem_read_address,
  input  logic                     mem_read_ready,
  input  logic [DATA_WIDTH-1:0]    mem_read_data,
  output logic                     mem_write_valid,
  output logic [ADDRESS_WIDTH-1:0] mem_write_address,
  output logic [DATA_WIDTH-1:0]    mem_write_data,
  input  logic                     mem_write_ready,
  output logic                     timeout_err
);
  typedef enum logic [1:0] {IDLE, REQUESTING, RELEASING} state_t;
  state_t state, state_next;
  logic op_write;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic sel_ready;
  assign sel_ready = op_write ? mem_write_ready : mem_read_ready;
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_next;
  always_comb begin
    state_next = state;
    case (state)
      IDLE:       state_next = req_valid ? REQUESTING : IDLE;
      REQUESTING: state_next = sel_ready ? RELEASING : REQUESTING;
      RELEASING:  state_next = sel_ready ? RELEASING : IDLE;
      default:    state_next = IDLE;
    endcase
  end
  always_comb begin
    req_ready       = state == IDLE && !reset;
    busy            = state != IDLE;
    mem_read_valid  = state == REQUESTING && !op_write;
    mem_write_valid = state == REQUESTING && op_write;
  end
  assign mem_read_address  = addr_q;
  assign mem_write_address = addr_q;
  assign mem_write_data    = wdata_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      op_write  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= state == RELEASING && !sel_ready;
      if (state == IDLE && req_valid) begin
        op_write <= req_write;
        addr_q   <= req_address;
        wdata_q  <= req_wdata;
      end
      if (state == RELEASING && !sel_ready) rsp_write <= op_write;
      if (state == REQUESTING && !op_write && mem_read_ready) rsp_data <= mem_read_data;
    end
  end
`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else if (state == IDLE) begin
      cnt <= '0;
    end else if (state == REQUESTING) begin
      cnt <= cnt == CW'(TIMEOUT_CYCLES) ? cnt : cnt + 1'b1;
      if (cnt >= CW'(TIMEOUT_CYCLES - 1)) timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif
endmodule
